teamplayer_io: RTL and testbench

TEAMPLAYER_IO -- requirements
Module: teamplayer_io

---
 rtl/teamplayer_io.sv | 177 +++++++++++++++++
 tb/tb_teamplayer_io.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/teamplayer_io.sv
// Sega multitap (TeamPlayer) device-side port model: serves a snapshot of up to
// four pads as a nibble stream over a TH-framed, TR/TL handshaked 7-bit port.
module teamplayer_io #(
  parameter int ACK_DLY = 14,
  parameter int TMO     = 81200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [47:0] pad_btn,
  input  logic [3:0]  pad_present,
  input  logic [3:0]  pad_six,
  input  logic [6:0]  port_in,
  input  logic [6:0]  port_dir,
  output logic [6:0]  port_out
);

  localparam int AW = ($clog2(ACK_DLY + 1) < 1) ? 1 : $clog2(ACK_DLY + 1);
  localparam int TW = ($clog2(TMO + 1) < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [4:0] IDX_MAX = 5'd19;

  typedef enum logic [1:0] {IDLE, ARMED, WAIT} state_t;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= IDX_MAX) ? IDX_MAX : v + 5'd1;
  endfunction

  function automatic logic [3:0] pad_nib(input logic [11:0] b, input logic [1:0] sel);
    case (sel)
      2'd0:    return ~{b[3], b[2], b[1], b[0]};
      2'd1:    return ~{b[7], b[4], b[6], b[5]};
      default: return ~{b[8], b[9], b[10], b[11]};
    endcase
  endfunction

  state_t        state;
  logic [4:0]    idx;
  logic [3:0]    nib;
  logic          tl;
  logic          pend;
  logic          tr_cap;
  logic [AW-1:0] ack_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_inc;
  logic [47:0]   snap_btn;
  logic [3:0]    snap_pres;
  logic [3:0]    snap_six;
  logic          th_p1;
  logic          tr_p1;
  logic          th_eff;
  logic          tr_eff;
  logic          th_fall;
  logic          th_rise;
  logic          tr_edge;
  logic          tmo_hit;
  logic [79:0]   stream;
  logic [4:0]    pos;
  logic [4:0]    idx_nxt;
  logic [3:0]    nib_nxt;
  logic [6:0]    drv;

  // A line the device drives itself reads as idle-high to the handshake logic.
  assign th_eff  = port_dir[6] | port_in[6];
  assign tr_eff  = port_dir[5] | port_in[5];
  assign th_fall = th_p1 & ~th_eff;
  assign th_rise = ~th_p1 & th_eff;
  assign tr_edge = tr_eff ^ tr_p1;

  assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
  assign tmo_inc = tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;

  // Full frame laid out from the snapshot; unused tail entries read as F.
  always_comb begin
    stream = '1;
    pos    = 5'd8;
    stream[15:0] = 16'h00F3;
    for (int p = 0; p < 4; p++) begin
      stream[16 + 4*p +: 4] = !snap_pres[p] ? 4'hF : (snap_six[p] ? 4'h1 : 4'h0);
    end
    for (int p = 0; p < 4; p++) begin
      if (snap_pres[p]) begin
        stream[{pos, 2'b00} +: 4] = pad_nib(snap_btn[12*p +: 12], 2'd0);
        pos = pos + 5'd1;
        stream[{pos, 2'b00} +: 4] = pad_nib(snap_btn[12*p +: 12], 2'd1);
        pos = pos + 5'd1;
        if (snap_six[p]) begin
          stream[{pos, 2'b00} +: 4] = pad_nib(snap_btn[12*p +: 12], 2'd2);
          pos = pos + 5'd1;
        end
      end
    end
  end

  assign idx_nxt = sat_inc(idx);
  assign nib_nxt = stream[{idx_nxt, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      nib       <= 4'h3;
      tl        <= 1'b1;
      pend      <= 1'b0;
      tr_cap    <= 1'b0;
      ack_cnt   <= '0;
      tmo_cnt   <= '0;
      snap_btn  <= '0;
      snap_pres <= '0;
      snap_six  <= '0;
      th_p1     <= 1'b1;
      tr_p1     <= 1'b1;
    end else begin
      th_p1 <= th_eff;
      tr_p1 <= tr_eff;
      if (!enable || th_rise) begin
        state   <= IDLE;
        idx     <= '0;
        nib     <= 4'h3;
        tl      <= 1'b1;
        pend    <= 1'b0;
        ack_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (th_fall) begin
              state     <= ARMED;
              snap_btn  <= pad_btn;
              snap_pres <= pad_present;
              snap_six  <= pad_six;
              tmo_cnt   <= '0;
            end
          end
          ARMED: begin
            if (tr_edge) begin
              state   <= WAIT;
              tr_cap  <= tr_eff;
              ack_cnt <= AW'(ACK_DLY);
              tmo_cnt <= '0;
            end else if (tmo_hit) begin
              idx     <= '0;
              nib     <= 4'h3;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
          WAIT: begin
            tmo_cnt <= tr_edge ? '0 : tmo_inc;
            if (ack_cnt == '0) begin
              idx <= idx_nxt;
              nib <= nib_nxt;
              tl  <= tr_cap;
              // A queued edge restarts the acknowledge with whatever TR is now.
              if (pend || tr_edge) begin
                state   <= WAIT;
                tr_cap  <= tr_eff;
                ack_cnt <= AW'(ACK_DLY);
                pend    <= 1'b0;
              end else begin
                state <= ARMED;
              end
            end else begin
              ack_cnt <= ack_cnt - 1'b1;
              if (tr_edge) pend <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign drv      = enable ? {2'b11, tl, nib} : 7'h7F;
  assign port_out = (~port_dir & port_in) | (port_dir & drv);

endmodule

// File: tb/tb_teamplayer_io.sv
// Randomized bench for teamplayer_io: a queue-based frame model built from the
// pad rules predicts every nibble/TL value and its handshake timing.
module tb_teamplayer_io;

  localparam int ACK   = 14;
  localparam int TMO_T = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [47:0] pad_btn;
  logic [3:0]  pad_present;
  logic [3:0]  pad_six;
  logic [6:0]  port_in;
  logic [6:0]  port_dir;
  logic [6:0]  port_out;
  logic        th;
  logic        tr;
  logic [4:0]  host_lo;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [3:0]  exp_s[$];
  int          k;
  logic        tl_exp;

  assign port_in = {th, tr, host_lo};

  teamplayer_io #(.ACK_DLY(ACK), .TMO(TMO_T)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pad_btn    (pad_btn),
    .pad_present(pad_present),
    .pad_six    (pad_six),
    .port_in    (port_in),
    .port_dir   (port_dir),
    .port_out   (port_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic logic [3:0] exp_at(input int i);
    return exp_s[(i > 19) ? 19 : i];
  endfunction

  task automatic build(input logic [47:0] b, input logic [3:0] p, input logic [3:0] s);
    logic [11:0] pb;
    exp_s.delete();
    exp_s.push_back(4'h3);
    exp_s.push_back(4'hF);
    exp_s.push_back(4'h0);
    exp_s.push_back(4'h0);
    for (int i = 0; i < 4; i++) exp_s.push_back(!p[i] ? 4'hF : (s[i] ? 4'h1 : 4'h0));
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        pb = b[12*i +: 12];
        exp_s.push_back(~{pb[3], pb[2], pb[1], pb[0]});
        exp_s.push_back(~{pb[7], pb[4], pb[6], pb[5]});
        if (s[i]) exp_s.push_back(~{pb[8], pb[9], pb[10], pb[11]});
      end
    end
    while (exp_s.size() < 20) exp_s.push_back(4'hF);
  endtask

  task automatic start_frame(input logic [47:0] b, input logic [3:0] p, input logic [3:0] s);
    pad_btn = b;
    pad_present = p;
    pad_six = s;
    build(b, p, s);
    th = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("frm_start", 8'(port_out[4:0]), 8'h13);
    chk("pass_th_tr", 8'(port_out[6:5]), 8'({th, tr}));
    // Inputs change after the snapshot; the stream must not follow them.
    pad_btn = rand48();
    pad_present = 4'($urandom);
    pad_six = 4'($urandom);
    k = 0;
    tl_exp = 1'b1;
  endtask

  task automatic end_frame();
    th = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("frm_end", 8'(port_out[4:0]), 8'h13);
  endtask

  task automatic tog_chk();
    logic [3:0] n0;
    logic       t0;
    n0 = exp_at(k);
    t0 = tl_exp;
    tr = ~tr;
    repeat (ACK + 1) @(posedge clk);
    @(negedge clk);
    chk("ack_hold", 8'(port_out[4:0]), 8'({t0, n0}));
    k++;
    tl_exp = tr;
    @(posedge clk); @(negedge clk);
    chk("nib_adv", 8'(port_out[4:0]), 8'({tl_exp, exp_at(k)}));
  endtask

  task automatic pend_test(input int ntog);
    logic [3:0] n0;
    logic       t0;
    logic       l1;
    n0 = exp_at(k);
    t0 = tl_exp;
    tr = ~tr;
    l1 = tr;
    for (int n = 1; n <= 3*ACK + 8; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == ACK + 1)   chk("pend_pre",   8'(port_out[4:0]), 8'({t0, n0}));
      if (n == ACK + 2)   chk("pend_adv1",  8'(port_out[4:0]), 8'({l1, exp_at(k + 1)}));
      if (n == 2*ACK + 2) chk("pend_hold",  8'(port_out[4:0]), 8'({l1, exp_at(k + 1)}));
      if (n == 2*ACK + 3) chk("pend_adv2",  8'(port_out[4:0]), 8'({tr, exp_at(k + 2)}));
      if (n == 3*ACK + 8) chk("pend_only2", 8'(port_out[4:0]), 8'({tr, exp_at(k + 2)}));
      if (n == 3 || (n == 6 && ntog == 3)) tr = ~tr;
    end
    k += 2;
    tl_exp = tr;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    th = 1'b1;
    tr = 1'b1;
    host_lo = 5'h0A;
    port_dir = 7'h7F;
    pad_btn = '0;
    pad_present = '0;
    pad_six = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 8'(port_out), 8'h73);
    port_dir = 7'h1F;
    #1;
    chk("rst_dir", 8'(port_out), 8'({th, tr, 5'h13}));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // UP on pad 0 only, all three-button
    start_frame(48'h1, 4'hF, 4'h0);
    repeat (9) tog_chk();
    end_frame();

    // Mixed presence, reads run past the end of the stream
    start_frame(rand48(), 4'b0101, 4'b0100);
    repeat (16) tog_chk();
    end_frame();

    // Longest possible stream, idx saturation at 19
    start_frame(rand48(), 4'hF, 4'hF);
    repeat (21) tog_chk();
    end_frame();

    for (int r = 0; r < 3; r++) begin
      start_frame(rand48(), 4'($urandom), 4'($urandom));
      repeat (8 + $urandom_range(0, 12)) tog_chk();
      end_frame();
    end

    // Edges arriving during the acknowledge window
    start_frame(rand48(), 4'b0101, 4'b0001);
    pend_test(2);
    tog_chk();
    pend_test(3);
    end_frame();

    // TH rise aborts a pending acknowledge
    start_frame(rand48(), 4'hF, 4'($urandom));
    repeat (5) tog_chk();
    tr = ~tr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tr = ~tr;
    @(posedge clk); @(negedge clk);
    th = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("th_abort", 8'(port_out[4:0]), 8'h13);
    repeat (ACK + 4) @(posedge clk);
    @(negedge clk);
    chk("abort_hold", 8'(port_out[4:0]), 8'h13);
    start_frame(rand48(), 4'($urandom), 4'($urandom));
    repeat (ACK + 4) @(posedge clk);
    @(negedge clk);
    chk("no_pend", 8'(port_out[4:0]), 8'h13);
    tog_chk();
    tog_chk();
    end_frame();

    // Timeout with no TR activity at idx 6
    start_frame(rand48(), 4'hF, 4'($urandom));
    repeat (6) tog_chk();
    repeat (TMO_T - ACK - 2) @(posedge clk);
    @(negedge clk);
    chk("tmo_before", 8'(port_out[4:0]), 8'({tl_exp, exp_at(6)}));
    @(posedge clk); @(negedge clk);
    chk("tmo_fire", 8'(port_out[4:0]), 8'({tl_exp, 4'h3}));
    k = 0;
    tog_chk();
    tog_chk();
    end_frame();

    // Multitap detached mid-frame
    start_frame(rand48(), 4'hF, 4'h0);
    repeat (3) tog_chk();
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("dis_drv", 8'(port_out[4:0]), 8'h1F);
    tr = ~tr;
    repeat (ACK + 3) @(posedge clk);
    @(negedge clk);
    chk("dis_hold", 8'(port_out[4:0]), 8'h1F);
    enable = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("en_idle", 8'(port_out[4:0]), 8'h13);
    th = 1'b1;
    @(posedge clk); @(negedge clk);

    // Reset mid-frame
    start_frame(rand48(), 4'($urandom), 4'($urandom));
    repeat (4) tog_chk();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid", 8'(port_out), 8'({th, tr, 5'h13}));
    port_dir = 7'h7F;
    #1;
    chk("rst_mid_dir", 8'(port_out), 8'h73);
    reset = 1'b0;
    port_dir = 7'h1F;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
